dmem_wbuf_responder: RTL
========================

Name: dmem_wbuf_responder

Overview:
Data-memory responder for the pipelined core's MEM stage. It services word loads and stores issued by the datapath. Stores are posted into a small write buffer and drained into a single-port word RAM in idle cycles. Loads read the RAM combinationally, with optional store-to-load forwarding from the buffer, and the block raises a stall to hold the MEM stage when it cannot accept a request.

Parameters:
ADDR_W, 8, RAM word-index width; RAM holds 2^ADDR_W 32-bit words
DEPTH, 4, write-buffer entries (power of 2, >=2)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset; one clock; reset is synchronous and active-low
we_dm  in  1  store request (MEM stage)
re_dm  in  1  load request (MEM stage)
addr  in  32  byte address; word index = addr[ADDR_W+1:2]
wd  in  32  store data
rd  out  32  load data, combinational, same cycle
stall  out  1  hold MEM stage; request not accepted this cycle
buf_empty  out  1  write buffer holds no pending stores
buf_count  out  $clog2(DEPTH)+1  pending store count

Behaviour:
- Reset (rst=0 at edge): head=tail=count=0. Pending entries are discarded. RAM contents are untouched. After reset: stall=0, buf_empty=1, buf_count=0.
- Addressing: addr[1:0] and addr[31:ADDR_W+2] are ignored. Out-of-range addresses alias modulo 2^ADDR_W words.
- Buffer entry = {index[ADDR_W-1:0], data[31:0]}. It is a FIFO with circular head/tail that wraps at DEPTH.
- Store accept: we_dm=1 and stall=0 -> entry enqueued at the edge.
- Drain: one entry (oldest) is written to RAM at the edge when the buffer is non-empty AND (no request this cycle OR stall=1).
  - Drains never occur in a cycle with an accepted request.
  - An accepted store and a drain are therefore never simultaneous.
- stall (combinational) = (we_dm & full) | (re_dm & hit & ~fwd_enabled).
  - hit = any valid entry index equals the load index.
  - A stall cycle always drains, which guarantees forward progress.
- Load (re_dm=1, stall=0):
  - With forwarding enabled and hit: rd = data of the youngest matching entry (search from tail-1 toward head).
  - Otherwise: rd = RAM[index].
- rd = 0 whenever re_dm=0 or stall=1.
- re_dm=1 & we_dm=1 is illegal: treat as a store; rd=0.
- Full: count==DEPTH. A store then stalls, one entry drains, and the store is accepted the next cycle (one-cycle stall).
- Counters: count increments on accept and decrements on drain; both never occur in the same cycle.
- buf_empty = (count==0).
- RAM: asynchronous read, synchronous write; no reset.

Optional Feature:
Macro WB_FWD_EN.
- Defined: a load that hits the buffer is forwarded the youngest matching data with no stall.
- Undefined: a load that hits stalls. The buffer drains one entry per stall cycle until no match remains, then the load completes from RAM. The forwarding mux and priority search are not built.

Decomposition:
- Shared package/header dmem_pkg:
  - DMEM_ADDR_W and DMEM_WB_DEPTH defaults.
  - Entry width localparam (ADDR_W+32).
  - Index-extraction function (addr -> word index).
- One sub-module, wbuf_fifo. It holds the circular entry storage, head/tail/count, enqueue/dequeue ports, full/empty flags and a parallel match vector per entry.
- The top holds the RAM, stall logic, drain arbitration and the forwarding priority select.

Test Plan:
- Reset: hold rst=0 for 2 cycles with we_dm=1 -> stall=0, buf_empty=1, buf_count=0, no enqueue. Release -> first store accepted.
- Forward: store 0x10<-0xDEADBEEF, next cycle load 0x10.
  - WB_FWD_EN: rd=0xDEADBEEF, stall=0.
  - Without it: stall=1 for one cycle, then rd=0xDEADBEEF.
- Full: 4 back-to-back stores 0x0,0x4,0x8,0xC <- 1,2,3,4 -> buf_count=4. A 5th store to 0x10 -> stall=1 one cycle, then accepted, buf_count=4.
- Idle drain and alias: after the fill, 4 idle cycles -> buf_empty=1. Load 0x8 -> rd=3. Load 0x408 (ADDR_W=8, aliases to index 2) -> rd=3.
- Youngest wins (WB_FWD_EN): store 0x20<-0xA, store 0x20<-0xB, load 0x20 -> rd=0xB. After full drain, load 0x20 -> rd=0xB.
- Reset mid-operation: 3 stores pending to 0x30..0x38, rst=0 one cycle -> buf_empty=1. Loads of 0x30..0x38 return the prior RAM contents.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared defaults and address helpers for the data-memory responder.
package dmem_pkg;

   localparam int DMEM_ADDR_W   = 8;
   localparam int DMEM_WB_DEPTH = 4;
   localparam int DMEM_ENTRY_W  = DMEM_ADDR_W + 32;

   // Full byte-to-word shift; callers keep only the low ADDR_W bits.
   function automatic logic [31:0] word_index(input logic [31:0] addr);
      return addr >> 2;
   endfunction

endpackage

// File: rtl/wbuf_fifo.sv
// Circular store buffer: {index, data} entries with per-slot match flags.
// WB_FWD_EN additionally exposes the tail pointer and slot data for forwarding.
module wbuf_fifo
   import dmem_pkg::*;
#(
   parameter int ADDR_W = DMEM_ADDR_W,
   parameter int DEPTH  = DMEM_WB_DEPTH,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enq,
   input  logic [ADDR_W-1:0] enq_idx,
   input  logic [31:0]       enq_data,
   input  logic              deq,
   output logic [ADDR_W-1:0] head_idx,
   output logic [31:0]       head_data,
   output logic              full,
   output logic              empty,
   output logic [CNT_W-1:0]  count,
   input  logic [ADDR_W-1:0] match_idx,
   output logic [DEPTH-1:0]  match
`ifdef WB_FWD_EN
   ,
   output logic [PTR_W-1:0]      tail_ptr,
   output logic [DEPTH-1:0][31:0] slot_data
`endif
);

   localparam int ENTRY_W = ADDR_W + 32;

   logic [ENTRY_W-1:0] slots [DEPTH];
   logic [PTR_W-1:0]   head;
   logic [PTR_W-1:0]   tail;
   logic [DEPTH-1:0]   valid;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; blocking here would make results depend on statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (enq) tail <= tail + PTR_W'(1);
         if (deq) head <= head + PTR_W'(1);
         if (enq && !deq)      count <= count + CNT_W'(1);
         else if (deq && !enq) count <= count - CNT_W'(1);
      end
   end

   // NOTE: entry storage is deliberately not reset; the pointers alone decide
   // which slots are live, and a reset port on the array would block RAM inference.
   always_ff @(posedge clk) begin
      if (enq) slots[tail] <= {enq_idx, enq_data};
   end

   assign head_idx  = slots[head][ENTRY_W-1:32];
   assign head_data = slots[head][31:0];
   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);

   // A slot is live when its distance from head is below the occupancy.
   for (genvar g = 0; g < DEPTH; g++) begin : g_slot
      logic [PTR_W-1:0] age;
      assign age      = PTR_W'(g) - head;
      assign valid[g] = ({1'b0, age} < count);
      assign match[g] = valid[g] && (slots[g][ENTRY_W-1:32] == match_idx);
`ifdef WB_FWD_EN
      assign slot_data[g] = slots[g][31:0];
`endif
   end

`ifdef WB_FWD_EN
   assign tail_ptr = tail;
`endif

endmodule

// File: rtl/dmem_wbuf_responder.sv
// MEM-stage data memory: posted-store buffer drained into a word RAM in idle cycles.
// Define WB_FWD_EN to forward buffered stores to loads instead of stalling on a hit.
module dmem_wbuf_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_W = DMEM_ADDR_W,
   parameter int DEPTH  = DMEM_WB_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we_dm,
   input  logic                     re_dm,
   input  logic [31:0]              addr,
   input  logic [31:0]              wd,
   output logic [31:0]              rd,
   output logic                     stall,
   output logic                     buf_empty,
   output logic [$clog2(DEPTH):0]   buf_count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [31:0]        idx_full;
   logic [ADDR_W-1:0]  index;
   logic [31-ADDR_W:0] unused_idx_hi;

   logic              load_req;
   logic              any_req;
   logic              hit;
   logic              enq;
   logic              drain;
   logic              full;
   logic              empty;
   logic [ADDR_W-1:0] head_idx;
   logic [31:0]       head_data;
   logic [DEPTH-1:0]  match;

   logic [31:0] ram [2**ADDR_W];

   assign idx_full      = word_index(addr);
   assign index         = idx_full[ADDR_W-1:0];
   assign unused_idx_hi = idx_full[31:ADDR_W];

   // A simultaneous load+store is handled as a store alone.
   assign load_req = re_dm & ~we_dm;
   assign any_req  = we_dm | re_dm;
   assign hit      = |match;

`ifdef WB_FWD_EN
   logic [PTR_W-1:0]       tail_ptr;
   logic [DEPTH-1:0][31:0] slot_data;
   logic [31:0]            fwd_data;
   logic [PTR_W-1:0]       slot;

   assign stall = we_dm & full;

   // Walk oldest to youngest so the youngest matching store wins.
   // NOTE: every always_comb output gets a default first; a path that leaves
   // one unassigned would infer a latch.
   always_comb begin
      fwd_data = '0;
      slot     = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         slot = tail_ptr - PTR_W'(k + 1);
         if (match[slot]) fwd_data = slot_data[slot];
      end
   end
`else
   assign stall = (we_dm & full) | (load_req & hit);
`endif

   // Stall cycles always drain, so a blocked request is guaranteed to progress.
   assign enq   = we_dm & ~stall;
   assign drain = rst & ~empty & (~any_req | stall);

   wbuf_fifo #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_wbuf (
      .clk       (clk),
      .rst       (rst),
      .enq       (enq),
      .enq_idx   (index),
      .enq_data  (wd),
      .deq       (drain),
      .head_idx  (head_idx),
      .head_data (head_data),
      .full      (full),
      .empty     (empty),
      .count     (buf_count),
      .match_idx (index),
      .match     (match)
`ifdef WB_FWD_EN
      ,
      .tail_ptr  (tail_ptr),
      .slot_data (slot_data)
`endif
   );

   always_ff @(posedge clk) begin
      if (drain) ram[head_idx] <= head_data;
   end

   always_comb begin
      rd = '0;
      if (load_req && !stall) begin
         rd = ram[index];
`ifdef WB_FWD_EN
         if (hit) rd = fwd_data;
`endif
      end
   end

   assign buf_empty = empty;

endmodule
